// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM encoding, widths and the saturating counter helper.
package mem_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } memState_t;

  function automatic logic [DATA_W-1:0] satInc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores to the data cache, stalls while an access is
// outstanding and emits one registered writeback record per instruction.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              exValid,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] storeData,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              regWrite,
  input  logic [REG_W-1:0]  dstReg,
  output logic              stall,
  output logic              dReq,
  output logic              dWe,
  output logic [DATA_W-1:0] dAddr,
  output logic [DATA_W-1:0] dWdata,
  input  logic              dRdy,
  input  logic [DATA_W-1:0] dRdata,
  output logic              wbValid,
  output logic [DATA_W-1:0] wbData,
  output logic [REG_W-1:0]  wbDst,
  output logic              wbRegWrite,
  output logic [DATA_W-1:0] waitCycles
);

  memState_t state, nextState;
  logic memOp;
  logic [REG_W-1:0] capDst;
  logic capRegWrite;

  assign memOp = memRead | memWrite;

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (exValid && memOp) begin
          nextState = MEM_ACCESS;
          stall     = 1'b1;
        end
      end
      MEM_ACCESS: begin
        stall = ~dRdy;
        if (dRdy) nextState = MEM_IDLE;
      end
      default: nextState = MEM_IDLE;
    endcase
  end

  // dWe/dAddr/dWdata double as the captured op, address and store data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= MEM_IDLE;
      dReq        <= 1'b0;
      dWe         <= 1'b0;
      dAddr       <= '0;
      dWdata      <= '0;
      capDst      <= '0;
      capRegWrite <= 1'b0;
      wbValid     <= 1'b0;
      wbData      <= '0;
      wbDst       <= '0;
      wbRegWrite  <= 1'b0;
      waitCycles  <= '0;
    end else begin
      state   <= nextState;
      wbValid <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (exValid && memOp) begin
            dReq        <= 1'b1;
            dWe         <= memWrite;
            dAddr       <= aluResult;
            dWdata      <= storeData;
            capDst      <= dstReg;
            capRegWrite <= regWrite & ~memWrite;
          end else if (exValid) begin
            wbValid    <= 1'b1;
            wbData     <= aluResult;
            wbDst      <= dstReg;
            wbRegWrite <= regWrite;
          end
        end
        MEM_ACCESS: begin
          if (dRdy) begin
            dReq       <= 1'b0;
            wbValid    <= 1'b1;
            wbData     <= dWe ? dAddr : dRdata;
            wbDst      <= capDst;
            wbRegWrite <= capRegWrite;
          end else begin
            waitCycles <= satInc(waitCycles);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected writebacks into a queue,
// an independent monitor pops and compares them whenever wbValid is seen.
module tb_mem_stage;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dst;
    logic        rw;
  } wbRec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        exValid, memRead, memWrite, regWrite;
  logic [15:0] aluResult, storeData;
  logic [3:0]  dstReg;
  logic        stall, dReq, dWe, dRdy, wbValid, wbRegWrite;
  logic [15:0] dAddr, dWdata, dRdata, wbData, waitCycles;
  logic [3:0]  wbDst;

  int checks = 0;
  int errors = 0;
  wbRec_t expQ[$];

  mem_stage dut (
    .clk(clk), .rst(rst), .exValid(exValid), .aluResult(aluResult),
    .storeData(storeData), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .dstReg(dstReg), .stall(stall), .dReq(dReq),
    .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dRdy(dRdy), .dRdata(dRdata),
    .wbValid(wbValid), .wbData(wbData), .wbDst(wbDst),
    .wbRegWrite(wbRegWrite), .waitCycles(waitCycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    exValid = 0; memRead = 0; memWrite = 0; regWrite = 0;
    aluResult = '0; storeData = '0; dstReg = '0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic rw,
                       input logic [15:0] alu, input logic [15:0] sd, input logic [3:0] dst);
    exValid = 1; memRead = rd; memWrite = wr; regWrite = rw;
    aluResult = alu; storeData = sd; dstReg = dst;
  endtask

  // Writeback monitor: every wbValid pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (!rst && wbValid) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got data=%h dst=%0d rw=%b expected none", wbData, wbDst, wbRegWrite);
      end else begin
        wbRec_t e;
        e = expQ.pop_front();
        if ({wbData, wbDst, wbRegWrite} !== e) begin
          errors++;
          $display("FAIL wb_record: got data=%h dst=%0d rw=%b expected data=%h dst=%0d rw=%b",
                   wbData, wbDst, wbRegWrite, e.data, e.dst, e.rw);
        end
      end
    end
  end

  initial begin
    int stallCnt;
    wbRec_t r;
    idleIn();
    dRdy = 0; dRdata = '0;
    rst = 1;
    #2;
    chk("rst_dReq", dReq, 0);
    chk("rst_dWe", dWe, 0);
    chk("rst_dAddr", dAddr, 0);
    chk("rst_dWdata", dWdata, 0);
    chk("rst_wbValid", wbValid, 0);
    chk("rst_wbData", wbData, 0);
    chk("rst_wbDst", wbDst, 0);
    chk("rst_wbRegWrite", wbRegWrite, 0);
    chk("rst_waitCycles", waitCycles, 0);
    cyc(); cyc();
    rst = 0;
    cyc();

    // ALU op: 1-cycle latency, no stall
    issue(0, 0, 1, 16'h1234, 16'h0, 4'd3);
    r = '{16'h1234, 4'd3, 1'b1}; expQ.push_back(r);
    chk("alu_stall", stall, 0);
    cyc(); idleIn();
    chk("alu_latency", wbValid, 1);
    chk("alu_stall_after", stall, 0);
    cyc();
    chk("alu_pulse", wbValid, 0);

    // Load with 3 wait cycles
    issue(1, 0, 1, 16'h0040, 16'h0, 4'd5);
    r = '{16'hBEEF, 4'd5, 1'b1}; expQ.push_back(r);
    stallCnt = stall ? 1 : 0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("ld_dReq", dReq, 1);
      chk("ld_dAddr", dAddr, 16'h0040);
      chk("ld_dWe", dWe, 0);
      if (stall) stallCnt++;
      cyc();
    end
    dRdy = 1; dRdata = 16'hBEEF;
    chk("ld_dAddr_rdy", dAddr, 16'h0040);
    if (stall) stallCnt++;
    cyc(); dRdy = 0; dRdata = '0; idleIn();
    chk("ld_stall_cycles", stallCnt, 4);
    chk("ld_wbValid", wbValid, 1);
    chk("ld_dReq_drop", dReq, 0);
    chk("ld_waitCycles", waitCycles, 3);
    cyc();

    // Store with immediate ready: 2-cycle latency
    issue(0, 1, 0, 16'h0100, 16'hA5A5, 4'd0);
    r = '{16'h0100, 4'd0, 1'b0}; expQ.push_back(r);
    cyc();
    chk("st_dReq", dReq, 1);
    chk("st_dWe", dWe, 1);
    chk("st_dWdata", dWdata, 16'hA5A5);
    chk("st_wb_early", wbValid, 0);
    dRdy = 1;
    cyc(); dRdy = 0; idleIn();
    chk("st_latency", wbValid, 1);
    chk("st_dReq_drop", dReq, 0);
    cyc();

    // Back-to-back loads, inputs held while stalled
    issue(1, 0, 1, 16'h0010, 16'h0, 4'd1);
    r = '{16'h1111, 4'd1, 1'b1}; expQ.push_back(r);
    cyc();
    chk("b2b_dAddr0", dAddr, 16'h0010);
    dRdy = 1; dRdata = 16'h1111;
    cyc(); dRdy = 0;
    issue(1, 0, 1, 16'h0011, 16'h0, 4'd2);
    r = '{16'h2222, 4'd2, 1'b1}; expQ.push_back(r);
    chk("b2b_gap", dReq, 0);
    chk("b2b_wb0", wbValid, 1);
    cyc();
    chk("b2b_dReq1", dReq, 1);
    chk("b2b_dAddr1", dAddr, 16'h0011);
    dRdy = 1; dRdata = 16'h2222;
    cyc(); dRdy = 0; idleIn();
    chk("b2b_wb1", wbValid, 1);
    cyc();
    chk("b2b_drained", expQ.size(), 0);

    // Reset during ACCESS abandons the access
    issue(1, 0, 1, 16'h0050, 16'h0, 4'd6);
    cyc(); idleIn();
    cyc();
    chk("rstacc_dReq_pre", dReq, 1);
    rst = 1;
    #1;
    chk("rstacc_dReq", dReq, 0);
    chk("rstacc_wbValid", wbValid, 0);
    chk("rstacc_waitCycles", waitCycles, 0);
    chk("rstacc_stall", stall, 0);
    cyc();
    rst = 0;
    cyc();
    chk("rstacc_noWb", wbValid, 0);
    issue(0, 0, 1, 16'h0777, 16'h0, 4'd7);
    r = '{16'h0777, 4'd7, 1'b1}; expQ.push_back(r);
    cyc(); idleIn();
    chk("rstacc_alu_wb", wbValid, 1);
    chk("rstacc_wait0", waitCycles, 0);
    cyc();

    // Read+write both set: treated as store, no register write
    issue(1, 1, 1, 16'h0200, 16'h5A5A, 4'd9);
    r = '{16'h0200, 4'd9, 1'b0}; expQ.push_back(r);
    cyc(); idleIn();
    chk("rw_dWe", dWe, 1);
    chk("rw_dWdata", dWdata, 16'h5A5A);
    dRdy = 1;
    cyc(); dRdy = 0;
    chk("rw_wb", wbValid, 1);
    cyc();

    // Saturation of waitCycles from a fresh reset
    rst = 1; cyc(); rst = 0; cyc();
    issue(1, 0, 1, 16'h0300, 16'h0, 4'd2);
    r = '{16'hCAFE, 4'd2, 1'b1}; expQ.push_back(r);
    cyc(); idleIn();
    repeat (65534) cyc();
    chk("sat_fffe", waitCycles, 16'hFFFE);
    cyc();
    chk("sat_ffff", waitCycles, 16'hFFFF);
    repeat (3) cyc();
    chk("sat_hold", waitCycles, 16'hFFFF);
    chk("sat_stall", stall, 1);
    dRdy = 1; dRdata = 16'hCAFE;
    cyc(); dRdy = 0;
    chk("sat_wb", wbValid, 1);
    cyc(); cyc();
    chk("final_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
